// File: rtl/ap_fifo_packet_framer_if.sv
// Handshake bundle between the host-side ap_fifo ports and the packet framer.
// master: the host/FIFO side; slave: the framer.
interface ap_fifo_packet_framer_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] in_r_dout;
  logic              in_r_empty_n;
  logic              in_r_read;
  logic [DATA_W-1:0] out_r_din;
  logic              out_r_full;
  logic              out_r_write;

  modport master (
    output in_r_dout, in_r_empty_n, out_r_full,
    input  in_r_read, out_r_din, out_r_write
  );

  modport slave (
    input  in_r_dout, in_r_empty_n, out_r_full,
    output in_r_read, out_r_din, out_r_write
  );
endinterface

// File: rtl/ap_fifo_packet_framer.sv
// Packet framer: forwards a header word and N payload words from in_r to
// out_r unchanged, then appends a trailer {xor checksum, seq, N}.
// A single output register (od_p1/vld_p1) decouples the two FIFOs.
module ap_fifo_packet_framer #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 32
) (
  input  logic             ip_clk,
  input  logic             ip_rst,
  ap_fifo_packet_framer_if.slave fifo,
  output logic             busy,
  output logic [LEN_W-1:0] pkt_count
);

  localparam int CSUM_W = DATA_W / 2;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_TRL = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] od_p1;
  logic              vld_p1;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  seq;
  logic [CSUM_W-1:0] csum;

  logic              can_load;
  logic              pop;
  logic              load_trl;
  logic              drain;
  logic [DATA_W-1:0] trailer;

  // Checksum contribution of one word: upper half folded onto lower half.
  function automatic logic [CSUM_W-1:0] fold_word(input logic [DATA_W-1:0] w);
    return w[DATA_W-1:CSUM_W] ^ w[CSUM_W-1:0];
  endfunction

  assign can_load         = ~vld_p1 | ~fifo.out_r_full;
  assign drain            = vld_p1 & ~fifo.out_r_full & ~ip_rst;
  assign fifo.in_r_read   = pop;
  assign fifo.out_r_write = drain;
  assign fifo.out_r_din   = od_p1;
  assign busy             = ~ip_rst & ((state != S_HDR) | vld_p1);
  assign trailer          = {csum, seq, len};

  // Next-state and load decode; the FSM only advances on a load.
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    load_trl = 1'b0;
    case (state)
      S_HDR: begin
        pop = fifo.in_r_empty_n & can_load;
        if (pop) begin
          state_n = (fifo.in_r_dout[LEN_W-1:0] != '0) ? S_PAY : S_TRL;
        end
      end
      S_PAY: begin
        pop = fifo.in_r_empty_n & can_load;
        if (pop && rem == LEN_W'(1)) begin
          state_n = S_TRL;
        end
      end
      S_TRL: begin
        load_trl = can_load;
        if (load_trl) begin
          state_n = S_HDR;
        end
      end
      default: state_n = S_HDR;
    endcase
    if (ip_rst) begin
      pop      = 1'b0;
      load_trl = 1'b0;
      state_n  = S_HDR;
    end
  end

  // FSM state register.
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state <= S_HDR;
    end else begin
      state <= state_n;
    end
  end

  // ---- stage p1: output register, length/checksum accumulators, counters ----
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      vld_p1    <= 1'b0;
      od_p1     <= '0;
      rem       <= '0;
      len       <= '0;
      csum      <= '0;
      seq       <= '0;
      pkt_count <= '0;
    end else begin
      if (pop || load_trl) begin
        vld_p1 <= 1'b1;
      end else if (drain) begin
        vld_p1 <= 1'b0;
      end
      if (pop && state == S_HDR) begin
        od_p1 <= fifo.in_r_dout;
        rem   <= fifo.in_r_dout[LEN_W-1:0];
        len   <= fifo.in_r_dout[LEN_W-1:0];
        csum  <= '0;
      end
      if (pop && state == S_PAY) begin
        od_p1 <= fifo.in_r_dout;
        csum  <= csum ^ fold_word(fifo.in_r_dout);
        rem   <= rem - LEN_W'(1);
      end
      if (load_trl) begin
        od_p1     <= trailer;
        seq       <= seq + LEN_W'(1);
        pkt_count <= pkt_count + LEN_W'(1);
      end
    end
  end

endmodule
